// File: rtl/cam_capture_rgb332.sv
// Camera capture: samples the RGB565 byte stream, packs each pixel to RGB332 and
// drives a linear frame-buffer write port with a one-cycle strobe per stored pixel.
module cam_capture_rgb332 #(
  parameter int AW    = 15,
  parameter int DW    = 8,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] addr_out,
  output logic [DW-1:0] data_out,
  output logic          regwrite,
  output logic          frame_done,
  output logic          overflow
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H);
  localparam logic [AW-1:0] BASE_STEP = AW'(IMG_W);

  typedef enum logic [1:0] {IDLE, WAIT_VS_LOW, BYTE1, BYTE2} state_t;

  state_t        state_q, state_d;
  logic [5:0]    b1_q, b1_d;
  logic          href_q;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          regwrite_q, regwrite_d;
  logic          frame_done_q, frame_done_d;
  logic          overflow_q, overflow_d;

  always_comb begin
    state_d      = state_q;
    b1_d         = b1_q;
    col_d        = col_q;
    row_d        = row_q;
    base_d       = base_q;
    addr_d       = addr_q;
    data_d       = data_q;
    regwrite_d   = 1'b0;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;

    case (state_q)
      IDLE: begin
        if (vsync) state_d = WAIT_VS_LOW;
      end
      WAIT_VS_LOW: begin
        col_d      = '0;
        row_d      = '0;
        base_d     = '0;
        overflow_d = 1'b0;
        if (!vsync) state_d = BYTE1;
      end
      BYTE1, BYTE2: begin
        if (vsync) begin
          // Frame boundary wins; any half-assembled pixel is simply abandoned.
          frame_done_d = 1'b1;
          state_d      = WAIT_VS_LOW;
        end else if (href) begin
          if (state_q == BYTE1) begin
            b1_d    = {px_data[7:5], px_data[2:0]};
            state_d = BYTE2;
          end else begin
            if (col_q < COL_MAX && row_q < ROW_MAX) begin
              addr_d     = base_q + AW'(col_q);
              data_d     = {b1_q, px_data[4:3]};
              regwrite_d = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
            if (col_q != COL_MAX) col_d = col_q + CW'(1);
            state_d = BYTE1;
          end
        end else begin
          state_d = BYTE1;
          // href falling edge ends the line; empty lines do not consume a row.
          if (href_q && col_q != '0) begin
            col_d = '0;
            if (row_q != ROW_MAX) begin
              row_d  = row_q + RW'(1);
              base_d = base_q + BASE_STEP;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      b1_q         <= '0;
      href_q       <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      base_q       <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      regwrite_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      b1_q         <= b1_d;
      href_q       <= href;
      col_q        <= col_d;
      row_q        <= row_d;
      base_q       <= base_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      regwrite_q   <= regwrite_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign addr_out   = addr_q;
  assign data_out   = data_q;
  assign regwrite   = regwrite_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule
